gin_id_scan_config: RTL and testbench
=====================================

GIN_ID_SCAN_CONFIG -- requirements
Module: gin_id_scan_config

Interface
REQ-001 SHALL have parameter NUM_MCC, default 12, number of MCC tag registers on the ID scan chain.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, bits per MCC tag register.
REQ-003 SHALL have port link_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cfg_start  input  1  request to (re)program the whole chain.
REQ-006 SHALL have port cfg_abort  input  1  abandon configuration in progress.
REQ-007 SHALL have port id_valid  input  1  id_data holds a valid tag word.
REQ-008 SHALL have port id_data  input  TAG_WIDTH  next tag ID to load; first word accepted lands in the MCC farthest from si_id.
REQ-009 SHALL have port id_ready  output  1  block will accept id_data this cycle.
REQ-010 SHALL have port se_id  output  1  scan enable to the MCC ID chain.
REQ-011 SHALL have port si_id  output  1  serial data into the chain head.
REQ-012 SHALL have port cfg_busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port cfg_done  output  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port configured  output  1  chain holds a complete, valid ID set; gates GIN enable downstream.
REQ-015 SHALL have port word_count  output  $clog2(NUM_MCC+1)  tag words fully shifted in the current pass.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE: cfg_start=1 -> LOAD, clear configured, clear word_count; otherwise stay.
REQ-018 LOAD: id_ready=1, se_id=0; on id_valid&id_ready capture id_data into TAG_WIDTH shift register, clear bit counter, -> SHIFT; id_valid=0 -> stay, no timeout.
REQ-019 SHIFT: se_id=1, si_id=shift-register MSB (word sent MSB first); shift register shifts left one bit per cycle; exactly TAG_WIDTH cycles per word.
REQ-020 After the TAG_WIDTH-th SHIFT cycle: word_count increments; if new count == NUM_MCC -> DONE, else -> LOAD.
REQ-021 DONE: cfg_done=1 for exactly one cycle, configured set to 1, -> IDLE.
REQ-022 se_id SHALL be high for exactly NUM_MCC*TAG_WIDTH cycles per completed pass and low in every other cycle, so tags hold outside SHIFT.
REQ-023 si_id SHALL be 0 whenever se_id=0.
REQ-024 id_ready SHALL be 0 in IDLE, SHIFT, DONE; words are never accepted outside LOAD.
REQ-025 With id_valid held high, one word costs TAG_WIDTH+1 cycles; cfg_done is high in cycle NUM_MCC*(TAG_WIDTH+1)+1, where cfg_start is sampled high at the end of cycle 0.
REQ-026 cfg_start while cfg_busy=1 SHALL be ignored.
REQ-027 cfg_abort=1 in LOAD or SHIFT SHALL force IDLE next cycle, se_id=0 immediately that cycle, configured stays 0, no cfg_done; a word being shifted is discarded.
REQ-028 cfg_abort and cfg_start both high in IDLE: abort wins, stay IDLE.
REQ-029 cfg_abort in DONE SHALL be ignored (completion stands).
REQ-030 configured SHALL remain 1 across IDLE until the next accepted cfg_start.
REQ-031 word_count SHALL hold its final value in IDLE and never exceed NUM_MCC.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, configured=0, word_count=0, shift register and bit counter=0.
REQ-033 While in reset and in the cycle after: se_id=0, si_id=0, id_ready=0, cfg_busy=0, cfg_done=0.
REQ-034 Reset mid-pass leaves chain contents undefined; configured=0 until a full new pass completes.

Verification
REQ-035 NUM_MCC=4, TAG_WIDTH=4, id_valid always 1, words 0xA,0x3,0xF,0x0 -> si_id sequence 1010 0011 1111 0000 with se_id high; cfg_done in cycle 21; configured=1.
REQ-036 Same, id_valid dropped 3 cycles before word 2 -> LOAD stalls 3 cycles, se_id=0 during stall, cfg_done in cycle 24, bit sequence unchanged.
REQ-037 cfg_abort during 2nd SHIFT cycle of word 3 -> IDLE next cycle, se_id=0 from abort cycle, no cfg_done, configured=0, word_count=2.
REQ-038 cfg_start pulsed during SHIFT -> ignored, single pass, one cfg_done only.
REQ-039 reset=0 for 1 cycle mid-LOAD after prior successful pass -> all outputs 0, configured=0; new cfg_start runs full 4-word pass.
REQ-040 Count se_id high cycles over any completed pass == NUM_MCC*TAG_WIDTH (16); id_ready never high outside LOAD.

Source files
------------

// File: rtl/gin_id_scan_config_if.sv
// Tag-word handshake between the ID source and the scan-chain configurator.
interface gin_id_scan_config_if #(
   parameter int TAG_WIDTH = 4
);
   logic                 id_valid;
   logic [TAG_WIDTH-1:0] id_data;
   logic                 id_ready;

   modport master (output id_valid, output id_data, input id_ready);
   modport slave  (input id_valid, input id_data, output id_ready);
endinterface

// File: rtl/gin_id_scan_config.sv
// Serialises NUM_MCC tag words into the MCC ID scan chain, MSB first, and
// flags the chain as configured once a complete pass has gone through.
//
// state | meaning
// IDLE  | waiting for cfg_start; configured/word_count hold
// LOAD  | id_ready high, waiting for the next tag word
// SHIFT | shifting the captured word out on si_id with se_id high
// DONE  | one-cycle cfg_done pulse, configured set on exit
module gin_id_scan_config #(
   parameter  int NUM_MCC   = 12,
   parameter  int TAG_WIDTH = 4,
   localparam int WC_W      = $clog2(NUM_MCC + 1),
   localparam int BC_W      = $clog2(TAG_WIDTH + 1)
) (
   input  logic                    link_clk,
   input  logic                    reset,
   input  logic                    cfg_start,
   input  logic                    cfg_abort,
   gin_id_scan_config_if.slave     id_if,
   output logic                    se_id,
   output logic                    si_id,
   output logic                    cfg_busy,
   output logic                    cfg_done,
   output logic                    configured,
   output logic [WC_W-1:0]         word_count
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

   state_e               state_q, state_d;
   logic [TAG_WIDTH-1:0] sh_q, sh_d;
   logic [BC_W-1:0]      bit_q, bit_d;
   logic [WC_W-1:0]      wc_q, wc_d;
   logic                 cfg_q, cfg_d;

   always_ff @(posedge link_clk) begin
      if (!reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         wc_q    <= '0;
         cfg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         wc_q    <= wc_d;
         cfg_q   <= cfg_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      sh_d           = sh_q;
      bit_d          = bit_q;
      wc_d           = wc_q;
      cfg_d          = cfg_q;
      id_if.id_ready = 1'b0;
      se_id          = 1'b0;
      si_id          = 1'b0;
      cfg_busy       = 1'b0;
      cfg_done       = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_start && !cfg_abort) begin
               state_d = LOAD;
               cfg_d   = 1'b0;
               wc_d    = '0;
            end
         end
         LOAD: begin
            id_if.id_ready = 1'b1;
            cfg_busy       = 1'b1;
            if (cfg_abort) begin
               state_d = IDLE;
            end else if (id_if.id_valid) begin
               sh_d    = id_if.id_data;
               bit_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            cfg_busy = 1'b1;
            // abort drops scan enable in the same cycle so no partial bit lands
            se_id    = !cfg_abort;
            si_id    = !cfg_abort && sh_q[TAG_WIDTH-1];
            if (cfg_abort) begin
               state_d = IDLE;
            end else begin
               sh_d  = sh_q << 1;
               bit_d = bit_q + BC_W'(1);
               if (bit_q == BC_W'(TAG_WIDTH - 1)) begin
                  wc_d    = wc_q + WC_W'(1);
                  state_d = (wc_q == WC_W'(NUM_MCC - 1)) ? DONE : LOAD;
               end
            end
         end
         DONE: begin
            cfg_busy = 1'b1;
            cfg_done = 1'b1;
            cfg_d    = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // strobes stay quiet while reset is held, before the state register clears
      if (!reset) begin
         id_if.id_ready = 1'b0;
         se_id          = 1'b0;
         si_id          = 1'b0;
         cfg_busy       = 1'b0;
         cfg_done       = 1'b0;
      end
   end

   assign configured = cfg_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_gin_id_scan_config.sv
// Bench for gin_id_scan_config: per-cycle comparison against a word/bit-level
// model, directed passes with literal expectations, then randomized traffic.
module tb_gin_id_scan_config;
   localparam int NUM = 4;
   localparam int TW  = 4;
   localparam int WCW = $clog2(NUM + 1);

   logic           link_clk;
   logic           reset;
   logic           cfg_start;
   logic           cfg_abort;
   logic           se_id, si_id, cfg_busy, cfg_done, configured;
   logic [WCW-1:0] word_count;

   gin_id_scan_config_if #(.TAG_WIDTH(TW)) id_if ();

   gin_id_scan_config #(.NUM_MCC(NUM), .TAG_WIDTH(TW)) dut (
      .link_clk   (link_clk),
      .reset      (reset),
      .cfg_start  (cfg_start),
      .cfg_abort  (cfg_abort),
      .id_if      (id_if),
      .se_id      (se_id),
      .si_id      (si_id),
      .cfg_busy   (cfg_busy),
      .cfg_done   (cfg_done),
      .configured (configured),
      .word_count (word_count)
   );

   initial link_clk = 1'b0;
   always #5 link_clk = ~link_clk;

   int cyc = 0;
   always @(posedge link_clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // model: whole-pass view -- active pass, word in flight (-1 = waiting), bit index
   bit m_act, m_done, m_cfg;
   int m_word, m_bit, m_words;

   bit   chk_en = 0;
   bit   hs_q   = 0;
   int   t0 = 0;
   int   done_cnt, done_at, se_cnt;
   bit   bits[$];

   always @(negedge link_clk) begin : compare
      bit e_rdy, e_se, e_si, e_busy, e_done;
      e_busy = reset && (m_act || m_done);
      e_rdy  = reset && m_act && (m_word < 0);
      e_se   = reset && m_act && (m_word >= 0) && !cfg_abort;
      e_si   = e_se && (((m_word >> (TW - 1 - m_bit)) & 1) != 0);
      e_done = reset && m_done;
      if (chk_en) begin
         chk("id_ready",   int'(id_if.id_ready), int'(e_rdy));
         chk("se_id",      int'(se_id),          int'(e_se));
         chk("si_id",      int'(si_id),          int'(e_si));
         chk("cfg_busy",   int'(cfg_busy),       int'(e_busy));
         chk("cfg_done",   int'(cfg_done),       int'(e_done));
         chk("configured", int'(configured),     int'(m_cfg));
         chk("word_count", int'(word_count),     m_words);
      end
      if (se_id) begin
         se_cnt++;
         bits.push_back(si_id);
      end
      if (cfg_done) begin
         done_cnt++;
         if (done_at < 0) done_at = cyc - t0;
      end
      hs_q = id_if.id_valid && id_if.id_ready;

      if (!reset) begin
         m_act = 0; m_done = 0; m_cfg = 0; m_word = -1; m_bit = 0; m_words = 0;
      end else if (m_done) begin
         m_done = 0;
         m_cfg  = 1;
      end else if (!m_act) begin
         if (cfg_start && !cfg_abort) begin
            m_act = 1; m_cfg = 0; m_words = 0; m_word = -1;
         end
      end else if (cfg_abort) begin
         m_act = 0;
      end else if (m_word < 0) begin
         if (id_if.id_valid) begin
            m_word = int'(id_if.id_data);
            m_bit  = 0;
         end
      end else begin
         m_bit++;
         if (m_bit == TW) begin
            m_words++;
            m_word = -1;
            if (m_words == NUM) begin
               m_act  = 0;
               m_done = 1;
            end
         end
      end
   end

   function automatic int packed_bits();
      int v = 0;
      foreach (bits[k]) v = (v << 1) | int'(bits[k]);
      return v;
   endfunction

   // one pass with words A,3,F,0; cycle 0 is the cycle cfg_start is driven
   task automatic run(input int ncyc, input int stall_w, input int stall_len,
                      input int abort_c, input int start2_c, input int rst_c);
      logic [TW-1:0] wq[$];
      wq = '{4'hA, 4'h3, 4'hF, 4'h0};
      done_cnt = 0; done_at = -1; se_cnt = 0; bits.delete();
      for (int i = 0; i < ncyc; i++) begin
         @(posedge link_clk);
         #1;
         if (hs_q && wq.size() > 0) void'(wq.pop_front());
         if (i == 0) t0 = cyc;
         cfg_start       = (i == 0) || (i == start2_c);
         cfg_abort       = (i == abort_c);
         reset           = (i != rst_c);
         id_if.id_valid  = !(stall_w >= 0 && i >= 1 + 5 * stall_w &&
                             i < 1 + 5 * stall_w + stall_len);
         id_if.id_data   = (wq.size() > 0) ? wq[0] : '0;
      end
      @(posedge link_clk);
      #1;
      cfg_start = 0; cfg_abort = 0; reset = 1; id_if.id_valid = 0;
      @(negedge link_clk);
   endtask

   initial begin
      reset = 0; cfg_start = 0; cfg_abort = 0;
      id_if.id_valid = 0; id_if.id_data = '0;
      m_act = 0; m_done = 0; m_cfg = 0; m_word = -1; m_bit = 0; m_words = 0;
      repeat (2) @(posedge link_clk);
      #1;
      chk_en = 1;
      reset  = 1;
      @(negedge link_clk);
      chk("rst_configured", int'(configured), 0);
      chk("rst_word_count", int'(word_count), 0);
      chk("rst_busy",       int'(cfg_busy),   0);

      run(26, -1, 0, -1, -1, -1);
      chk("basic_bits",     packed_bits(), 'hA3F0);
      chk("basic_done_at",  done_at,  21);
      chk("basic_se_cnt",   se_cnt,   16);
      chk("basic_configured", int'(configured), 1);

      run(30, 2, 3, -1, -1, -1);
      chk("stall_bits",     packed_bits(), 'hA3F0);
      chk("stall_done_at",  done_at,  24);
      chk("stall_se_cnt",   se_cnt,   16);

      run(20, -1, 0, 13, -1, -1);
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_se_cnt",   se_cnt,   9);
      chk("abort_bits",     packed_bits(), 'h147);
      chk("abort_configured", int'(configured), 0);
      chk("abort_word_count", int'(word_count), 2);

      run(26, -1, 0, -1, 3, -1);
      chk("restart_done_cnt", done_cnt, 1);
      chk("restart_done_at",  done_at,  21);

      run(10, -1, 0, -1, -1, 6);
      chk("midrst_configured", int'(configured), 0);
      chk("midrst_word_count", int'(word_count), 0);
      chk("midrst_done_cnt",   done_cnt, 0);
      run(26, -1, 0, -1, -1, -1);
      chk("postrst_done_at",    done_at, 21);
      chk("postrst_se_cnt",     se_cnt,  16);
      chk("postrst_configured", int'(configured), 1);

      for (int i = 0; i < 3000; i++) begin
         @(posedge link_clk);
         #1;
         cfg_start      = ($urandom % 8) == 0;
         cfg_abort      = ($urandom % 40) == 0;
         reset          = ($urandom % 300) != 0;
         id_if.id_valid = ($urandom % 4) != 0;
         id_if.id_data  = TW'($urandom);
      end
      @(negedge link_clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
